nibble_pair_deserializer: RTL and testbench
===========================================

# nibble_pair_deserializer

Bit-serial front end for the nibble breakout stage. Accepts a serial stream under a valid/ready handshake and assembles each 2×W-bit frame into two W-bit nibbles. The first nibble is `out_a` and feeds breakout input `in_1`; the second is `out_b` and feeds `in_2`. Provides a one-word output register with valid/ready backpressure, start-of-frame resynchronisation, and a resync error pulse.

## Interface
- `W`, default 4: nibble width; frame length is 2·W bits. Must be ≥ 2.
- `MSB_FIRST`, default 1: 1 means the first received bit is bit W-1 of `out_a`; 0 means the first received bit is bit 0 of `out_a`.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ser_in`  in  1  serial data bit.
- `ser_valid`  in  1  `ser_in` is valid this cycle.
- `ser_start`  in  1  qualified by `ser_valid`; marks the current bit as the first bit of a frame.
- `ser_ready`  out  1  deserializer can accept a bit this cycle.
- `out_a`  out  W  first nibble of the frame, to breakout `in_1`.
- `out_b`  out  W  second nibble of the frame, to breakout `in_2`.
- `out_valid`  out  1  `out_a`/`out_b` hold a complete frame.
- `out_ready`  in  1  consumer takes the frame when `out_valid && out_ready`.
- `err_resync`  out  1  one-cycle pulse when a started frame is abandoned.

## Operation
- Bit accept: `ser_valid && ser_ready`. Output take: `out_valid && out_ready`.
- State machine, `st`:
  - `IDLE`: waiting for the first bit. Any accepted bit, with or without `ser_start`, begins a frame: `cnt` ← 1, go to `SHIFT`.
  - `SHIFT`: each accepted bit is shifted into `sreg`, and `cnt` increments.
    - On the accept that makes `cnt` equal 2W, the frame is complete.
    - If the output register is free or being taken this cycle, load `out_a`/`out_b` and go to `IDLE` (or to `SHIFT` with `cnt`=0 if continuing).
    - Otherwise keep the frame in `sreg` and go to `FULL`.
  - `FULL`: `ser_ready`=0. When a take occurs, move `sreg` into the output register and go to `IDLE`.
- Simplification: after a frame completes, the FSM returns to `IDLE`. `IDLE` accepts the next bit in the same cycle, so there is no bubble.
- `ser_ready` = (`st` != `FULL`). It is combinational from state only and never depends on `ser_valid`.
- Resync: if an accepted bit has `ser_start`=1 while `st`=`SHIFT` and `cnt`≠0:
  - discard the partial frame;
  - treat the bit as bit 0 of a new frame (`cnt` ← 1);
  - pulse `err_resync` for one cycle.
  - `ser_start` in `IDLE` is normal and raises no error.
- Output register:
  - `out_valid` sets on load.
  - On a take with no simultaneous load, `out_valid` clears.
  - On a take with a simultaneous load, `out_valid` stays 1 and the new data replaces the old.
  - `out_a`/`out_b` are stable while `out_valid && !out_ready`.
- Nibble split: with `MSB_FIRST`=1, frame bits b0…b(2W-1) map to `out_a` = {b0…b(W-1)} and `out_b` = {bW…b(2W-1)}, with b0 in the MSB of `out_a`. `MSB_FIRST`=0 mirrors each nibble.
- Counter width is $clog2(2W+1). Wrap-around is impossible: completion always resets `cnt`.

## Timing
- Reset values:
  - `out_a`=0, `out_b`=0, `out_valid`=0, `err_resync`=0;
  - `st`=`IDLE`, `cnt`=0, `sreg`=0;
  - `ser_ready`=1 during and immediately after reset.
- Reset mid-frame or in `FULL`: all state is cleared immediately and asynchronously; the partial frame and any held word are lost.
- Latency: `out_valid` rises on the clock edge that accepts the 2W-th bit, i.e. it is visible the cycle after that bit is presented.
- Throughput: one frame per 2W cycles with `out_ready` tied high.
- Backpressure: at most one complete frame is buffered in `sreg` plus one in the output register. Bit 2W+1 of the following frame stalls, since `ser_ready`=0 in `FULL`.
- Leaving `FULL`: `ser_ready` returns high the cycle after the take.
- `err_resync` is registered: it is high the cycle after the offending bit is accepted.

## Structure
- Shared package `nibble_pkg`:
  - `NIBBLE_W` default (4);
  - the `FRAME_LEN` = 2·W localparam;
  - `st_t` enum {`IDLE`, `SHIFT`, `FULL`}.
- The breakout stage imports `NIBBLE_W` from the same package.
- One sub-module, `serial_shift_reg`: a parameterised N-bit shift register with enable, clear, and direction parameter. It is instantiated once, with N = 2W.
- The FSM, counter, and output register live in the top module.

## Test plan
- Reset, then 8 bits 1,0,1,0,0,1,1,0 with `ser_start` on the first bit and `out_ready`=1 → `out_a`=4'hA, `out_b`=4'h6, `out_valid` high for exactly one cycle, `err_resync`=0.
- Two frames back-to-back, 16 consecutive valid bits (0xA6 then 0x3C), `out_ready`=1 → `out_valid` pulses 8 cycles apart, with values A/6 then 3/C, and `ser_ready` never low.
- `out_ready`=0 through two frames (0x12, 0x34) → `out_valid` stays at 1/2 and `ser_ready` drops after bit 16. Raising `out_ready` for one cycle → output becomes 3/4, and `ser_ready`=1 the next cycle.
- 5 bits, then `ser_start` with frame 0xF0 → `err_resync` pulses once, and the output is `out_a`=4'hF, `out_b`=4'h0.
- Random `ser_valid` gaps inside frame 0x5A → output 5/A, unaffected by the gaps.
- `rst_n` asserted at bit 4 and while in `FULL` → all outputs 0 and `ser_ready`=1 immediately; the next full frame decodes correctly.

Source files
------------

// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble deserializer and the breakout stage it feeds.
package nibble_pkg;

  localparam int NIBBLE_W  = 4;
  localparam int FRAME_LEN = 2 * NIBBLE_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } st_t;

endpackage

// File: rtl/serial_shift_reg.sv
// N-bit serial-in shift register with enable, clear and selectable shift direction.
// q_next exposes the value being written this cycle so a caller can capture it early.
module serial_shift_reg #(
  parameter int N          = 8,
  parameter int SHIFT_LEFT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic         din,
  output logic [N-1:0] q,
  output logic [N-1:0] q_next
);

  // clr together with en restarts the register with din as the only valid bit.
  always_comb begin
    // NOTE: default assignment first so no path leaves q_next unassigned (no latch).
    q_next = q;
    if (en) begin
      if (SHIFT_LEFT != 0) begin
        q_next = clr ? {{(N-1){1'b0}}, din} : {q[N-2:0], din};
      end else begin
        q_next = clr ? {din, {(N-1){1'b0}}} : {din, q[N-1:1]};
      end
    end else if (clr) begin
      q_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      // NOTE: non-blocking assignment for all clocked state avoids simulation races.
      q <= q_next;
    end
  end

endmodule

// File: rtl/nibble_pair_deserializer.sv
// Bit-serial deserializer: assembles 2*W-bit frames into out_a/out_b nibble pairs
// behind a one-word valid/ready output register, with start-of-frame resync.
module nibble_pair_deserializer
  import nibble_pkg::*;
#(
  parameter int W         = NIBBLE_W,
  parameter int MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ser_in,
  input  logic         ser_valid,
  input  logic         ser_start,
  output logic         ser_ready,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         err_resync
);

  localparam int N  = 2 * W;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  st_t           st;
  logic [CW-1:0] cnt;
  logic [N-1:0]  sreg;
  logic [N-1:0]  sreg_next;
  logic [N-1:0]  load_word;
  logic [W-1:0]  load_a;
  logic [W-1:0]  load_b;

  logic accept;
  logic take;
  logic resync;
  logic start_new;
  logic complete;
  logic load_direct;
  logic load_held;

  assign ser_ready = (st != FULL);
  assign accept    = ser_valid && ser_ready;
  assign take      = out_valid && out_ready;

  // A start marker inside a partial frame abandons it; in IDLE it is just a normal first bit.
  assign resync      = accept && ser_start && (st == SHIFT) && (cnt != '0);
  assign start_new   = accept && ((st == IDLE) || resync);
  assign complete    = accept && (st == SHIFT) && !resync && (cnt == LAST_CNT);
  assign load_direct = complete && (!out_valid || out_ready);
  assign load_held   = (st == FULL) && take;

  serial_shift_reg #(
    .N          (N),
    .SHIFT_LEFT ((MSB_FIRST != 0) ? 1 : 0)
  ) u_sreg (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (accept),
    .clr    (start_new),
    .din    (ser_in),
    .q      (sreg),
    .q_next (sreg_next)
  );

  // A direct load takes the frame including the bit arriving this cycle.
  assign load_word = load_held ? sreg : sreg_next;

  if (MSB_FIRST != 0) begin : g_msb_first
    assign load_a = load_word[N-1:W];
    assign load_b = load_word[W-1:0];
  end else begin : g_lsb_first
    assign load_a = load_word[W-1:0];
    assign load_b = load_word[N-1:W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      cnt        <= '0;
      out_a      <= '0;
      out_b      <= '0;
      out_valid  <= 1'b0;
      err_resync <= 1'b0;
    end else begin
      err_resync <= resync;

      if (load_direct || load_held) begin
        out_a     <= load_a;
        out_b     <= load_b;
        out_valid <= 1'b1;
      end else if (take) begin
        out_valid <= 1'b0;
      end

      case (st)
        IDLE: begin
          if (accept) begin
            cnt <= ONE_CNT;
            st  <= SHIFT;
          end
        end
        SHIFT: begin
          if (resync) begin
            cnt <= ONE_CNT;
          end else if (complete) begin
            cnt <= '0;
            st  <= load_direct ? IDLE : FULL;
          end else if (accept) begin
            cnt <= cnt + ONE_CNT;
          end
        end
        FULL: begin
          if (take) begin
            st <= IDLE;
          end
        end
        default: begin
          st  <= IDLE;
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_pair_deserializer.sv
// Directed bench for nibble_pair_deserializer (W=4, MSB first): vector table plus
// hand sequences for back-to-back, backpressure, resync and asynchronous reset.
module tb_nibble_pair_deserializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ser_in = 1'b0;
  logic       ser_valid = 1'b0;
  logic       ser_start = 1'b0;
  logic       ser_ready;
  logic [3:0] out_a;
  logic [3:0] out_b;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       err_resync;

  int checks = 0;
  int failures = 0;

  nibble_pair_deserializer #(.W(4), .MSB_FIRST(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ser_in     (ser_in),
    .ser_valid  (ser_valid),
    .ser_start  (ser_start),
    .ser_ready  (ser_ready),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err_resync (err_resync)
  );

  always #5 clk = ~clk;

  // Passive monitor sampling on the falling edge.
  int         cyc = 0;
  int         rise_cnt = 0;
  int         last_rise = 0;
  int         prev_rise = 0;
  int         nrdy_cnt = 0;
  int         err_cnt = 0;
  logic       ov_q = 1'b0;
  logic [7:0] rise_word_last = 8'h00;
  logic [7:0] rise_word_prev = 8'h00;

  always @(negedge clk) begin
    cyc  <= cyc + 1;
    ov_q <= out_valid;
    if (out_valid && !ov_q) begin
      rise_cnt       <= rise_cnt + 1;
      prev_rise      <= last_rise;
      last_rise      <= cyc;
      rise_word_prev <= rise_word_last;
      rise_word_last <= {out_a, out_b};
    end
    if (!ser_ready) nrdy_cnt <= nrdy_cnt + 1;
    if (err_resync) err_cnt <= err_cnt + 1;
  end

  typedef struct {
    string      name;
    logic [7:0] frame;
    logic [7:0] gaps;
    logic [3:0] exp_a;
    logic [3:0] exp_b;
  } vec_t;

  vec_t vecs [0:4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the edge that accepted the bit.
  task automatic send_bit(input logic b, input logic st);
    int waited = 0;
    ser_valid = 1'b1;
    ser_in    = b;
    ser_start = st;
    @(negedge clk);
    while (!ser_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!ser_ready) begin
      checks++;
      failures++;
      $display("FAIL ser_ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1;
    ser_valid = 1'b0;
    ser_start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] frame, input logic [7:0] gaps);
    for (int i = 7; i >= 0; i--) begin
      if (gaps[i]) idle_cycles(int'($urandom_range(1, 3)));
      send_bit(frame[i], i == 7);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int n0;
    int e0;

    vecs[0] = '{"frame_a6",     8'hA6, 8'h00, 4'hA, 4'h6};
    vecs[1] = '{"frame_3c",     8'h3C, 8'h00, 4'h3, 4'hC};
    vecs[2] = '{"frame_5a_gap", 8'h5A, 8'b0101_0110, 4'h5, 4'hA};
    vecs[3] = '{"frame_81_gap", 8'h81, 8'b1000_0001, 4'h8, 4'h1};
    vecs[4] = '{"frame_ff",     8'hFF, 8'h00, 4'hF, 4'hF};

    // Reset state, checked while reset is held.
    #1 rst_n = 1'b0;
    #20;
    check("rst_ser_ready", ser_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_a", out_a, 0);
    check("rst_out_b", out_b, 0);
    check("rst_err", err_resync, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(2);
    check("post_rst_ser_ready", ser_ready, 1);

    // Vector table: single frames, out_ready high.
    out_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].frame, vecs[v].gaps);
      @(negedge clk);
      check({vecs[v].name, "_valid"}, out_valid, 1);
      check({vecs[v].name, "_a"}, out_a, vecs[v].exp_a);
      check({vecs[v].name, "_b"}, out_b, vecs[v].exp_b);
      check({vecs[v].name, "_err"}, err_resync, 0);
      @(negedge clk);
      check({vecs[v].name, "_valid_drop"}, out_valid, 0);
      @(posedge clk);
      #1;
    end

    // Two back-to-back frames: pulses 8 cycles apart, ser_ready never low.
    r0 = rise_cnt;
    n0 = nrdy_cnt;
    e0 = err_cnt;
    send_frame(8'hA6, 8'h00);
    send_frame(8'h3C, 8'h00);
    idle_cycles(2);
    check("b2b_rises", rise_cnt - r0, 2);
    check("b2b_spacing", last_rise - prev_rise, 8);
    check("b2b_first_word", rise_word_prev, 8'hA6);
    check("b2b_second_word", rise_word_last, 8'h3C);
    check("b2b_ready_low_cycles", nrdy_cnt - n0, 0);
    check("b2b_err", err_cnt - e0, 0);

    // Backpressure: two frames with out_ready low, second one parks in the shift register.
    out_ready = 1'b0;
    send_frame(8'h12, 8'h00);
    send_frame(8'h34, 8'h00);
    ser_valid = 1'b1;
    ser_in    = 1'b1;
    ser_start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_ready_low", ser_ready, 0);
      check("bp_hold", {out_valid, out_a, out_b}, 9'h112);
      @(posedge clk);
      #1;
    end
    ser_valid = 1'b0;
    ser_start = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp_after_take", {out_valid, out_a, out_b}, 9'h134);
    check("bp_ready_back", ser_ready, 1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_drained", out_valid, 0);
    @(posedge clk);
    #1;

    // Resync: 5 bits of a frame, then a new start with frame 0xF0.
    e0 = err_cnt;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_frame(8'hF0, 8'h00);
    @(negedge clk);
    check("resync_valid", out_valid, 1);
    check("resync_a", out_a, 4'hF);
    check("resync_b", out_b, 4'h0);
    idle_cycles(2);
    check("resync_err_pulses", err_cnt - e0, 1);

    // Reset in the middle of a frame (after bit 4).
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outs", {out_valid, out_a, out_b, err_resync}, 10'h000);
    check("midrst_ready", ser_ready, 1);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(8'hC3, 8'h00);
    @(negedge clk);
    check("midrst_next_frame", {out_valid, out_a, out_b}, 9'h1C3);
    @(posedge clk);
    #1;

    // Reset while FULL.
    out_ready = 1'b0;
    send_frame(8'h11, 8'h00);
    send_frame(8'h22, 8'h00);
    @(negedge clk);
    check("full_before_rst", ser_ready, 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("fullrst_outs", {out_valid, out_a, out_b, err_resync}, 10'h000);
    check("fullrst_ready", ser_ready, 1);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send_frame(8'h96, 8'h00);
    @(negedge clk);
    check("fullrst_next_frame", {out_valid, out_a, out_b}, 9'h196);
    idle_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
